// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching fetch stage: credit-limited in-order requests, prefetch queue, one-cycle redirect
// Optional FETCH_PERF_EN adds perf_fetched/perf_bubble/perf_dropped event counters.
module fetch_queue #(
    parameter int              WORD      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            stallD,
    output logic            validD,
    output logic [WORD-1:0] pcD,
    output logic [WORD-1:0] instrD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubble,
    output logic [31:0]     perf_dropped
`endif
);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int PW  = $clog2(DEPTH) + 1;
    localparam int PPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [WORD-1:0] r_fetch_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [WORD-1:0] r_q_pc    [DEPTH];
    logic [WORD-1:0] r_q_instr [DEPTH];
    logic [WORD-1:0] r_pp_pc   [MAX_OUTST];
    logic [PPW-1:0]  r_pp_wr;
    logic [PPW-1:0]  r_pp_rd;

    logic [PW-1:0]   w_count;
    logic [PW:0]     w_used;
    logic [PW-2:0]   w_wr_idx;
    logic [PW-2:0]   w_rd_idx;
    logic            w_grant;
    logic            w_resp;
    logic            w_discard;
    logic            w_enq;
    logic            w_deq;
    logic [OW-1:0]   w_outst_next;
    logic            w_unused;

    function automatic logic [PPW-1:0] pp_inc(input logic [PPW-1:0] p);
        return (p == PPW'(MAX_OUTST - 1)) ? '0 : p + PPW'(1);
    endfunction

    assign w_unused  = &{1'b0, redirect_pc[1:0]};
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_wr_idx  = r_wr_ptr[PW-2:0];
    assign w_rd_idx  = r_rd_ptr[PW-2:0];
    // Credits cover both queued and in-flight entries, so a response always finds room.
    assign w_used    = {1'b0, w_count} + (PW+1)'(r_outst);
    assign imem_req  = !reset && !redirect && (w_used < (PW+1)'(DEPTH)) && (r_outst < OW'(MAX_OUTST));
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;
    assign w_resp    = imem_rvalid && (r_outst != '0);
    assign w_discard = w_resp && (redirect || (r_drop != '0));
    assign w_enq     = w_resp && !w_discard;
    assign validD    = (w_count != '0);
    assign w_deq     = validD && !stallD && !redirect;
    assign pcD       = validD ? r_q_pc[w_rd_idx]    : '0;
    assign instrD    = validD ? r_q_instr[w_rd_idx] : '0;

    always_comb begin
        w_outst_next = r_outst;
        if (w_grant && !w_resp)
            w_outst_next = r_outst + OW'(1);
        else if (!w_grant && w_resp)
            w_outst_next = r_outst - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pp_wr    <= '0;
            r_pp_rd    <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (redirect)
                r_fetch_pc <= {redirect_pc[WORD-1:2], 2'b00};
            else if (w_grant)
                r_fetch_pc <= r_fetch_pc + WORD'(4);
            // Everything still in flight after this cycle belongs to the old stream.
            if (redirect)
                r_drop <= w_outst_next;
            else if (w_resp && (r_drop != '0))
                r_drop <= r_drop - OW'(1);
            if (w_grant)
                r_pp_wr <= pp_inc(r_pp_wr);
            if (w_resp)
                r_pp_rd <= pp_inc(r_pp_rd);
            if (redirect) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_enq)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_deq)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant)
            r_pp_pc[r_pp_wr] <= r_fetch_pc;
        if (w_enq) begin
            r_q_pc[w_wr_idx]    <= r_pp_pc[r_pp_rd];
            r_q_instr[w_wr_idx] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_dropped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_bubble  <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_deq)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (!validD && !stallD)
                r_perf_bubble <= r_perf_bubble + 32'd1;
            if (w_discard)
                r_perf_dropped <= r_perf_dropped + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubble  = r_perf_bubble;
    assign perf_dropped = r_perf_dropped;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue with a variable-latency in-order memory
module tb_fetch_queue;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stallD;
    logic        validD;
    logic [31:0] pcD;
    logic [31:0] instrD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.WORD(32), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stallD(stallD),
        .validD(validD), .pcD(pcD), .instrD(instrD)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble), .perf_dropped(perf_dropped)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        gnt_en = 1'b1;
    logic [31:0] exp_addr;
    logic        s_valid, s_req;
    logic [31:0] s_pc, s_instr;
    logic        hold_chk;
    logic [31:0] hold_pc, hold_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: present memory response, sample mid-cycle, score, advance to next negedge.
    task automatic step();
        logic [31:0] e;
        mreq_t       d;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        imem_gnt = gnt_en;
        #1;
        s_valid = validD;
        s_req   = imem_req;
        s_pc    = pcD;
        s_instr = instrD;
        if (hold_chk) begin
            chk("stall_validD", {31'b0, validD}, 32'd1);
            chk("stall_pcD", pcD, hold_pc);
            chk("stall_instrD", instrD, hold_instr);
        end
        hold_chk   = validD && stallD && !redirect && !reset;
        hold_pc    = pcD;
        hold_instr = instrD;
        if (validD && !stallD && !redirect && !reset) begin
            chk("deq_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pcD", pcD, e);
                chk("instrD", instrD, e ^ KEY);
            end
        end
        if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, exp_addr);
            mq.push_back('{imem_addr, cyc + lat});
            sb.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
        end
        if (reset) begin
            sb.delete();
            exp_addr = RST_PC;
        end else if (redirect) begin
            sb.delete();
            exp_addr = {redirect_pc[31:2], 2'b00};
        end
        if (imem_rvalid)
            d = mq.pop_front();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp, input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (!s_valid && k < budget);
        chk({tag, "_seen"}, {31'b0, s_valid}, 32'd1);
        chk(tag, s_pc, exp);
    endtask

    task automatic wait_outst(input int n, input int budget);
        int k = 0;
        while (mq.size() != n && k < budget) begin
            step();
            k++;
        end
        chk("outst_reached", 32'(mq.size()), 32'(n));
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stallD = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        exp_addr = RST_PC; hold_chk = 1'b0;

        step();
        chk("rst_req", {31'b0, s_req}, 32'd0);
        step();
        reset = 1'b0;

        // 1-cycle memory: request at c0, response c1, validD c2, then one per cycle
        step();
        chk("rst_validD", {31'b0, s_valid}, 32'd0);
        chk("rst_pcD", s_pc, 32'd0);
        chk("rst_instrD", s_instr, 32'd0);
        chk("first_req", {31'b0, s_req}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_dropped", perf_dropped, 32'd0);
`endif
        step();
        chk("c1_validD", {31'b0, s_valid}, 32'd0);
        step();
        chk("c2_validD", {31'b0, s_valid}, 32'd1);
        chk("c2_pcD", s_pc, 32'h0);
        step();
        chk("c3_validD", {31'b0, s_valid}, 32'd1);
        chk("c3_pcD", s_pc, 32'h4);

        stallD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_at_8", s_pc, 32'h8);
        end
        chk("stall_req_off", {31'b0, s_req}, 32'd0);
        stallD = 1'b0;
        step();
        chk("release_pcD", s_pc, 32'h8);
        step();
        chk("release_next_pcD", s_pc, 32'hC);
        repeat (6) step();

        // Redirect with two requests in flight
        lat = 3;
        wait_outst(2, 20);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        chk("redir_req_off", {31'b0, s_req}, 32'd0);
        redirect = 1'b0;
        wait_valid("redir_103", 32'h100, 20);
        repeat (8) step();

        // Redirect while a response and grant are active, 1-cycle memory latency N+3
        lat = 1;
        repeat (6) step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        step();
        chk("n1_validD", {31'b0, s_valid}, 32'd0);
        step();
        chk("n2_validD", {31'b0, s_valid}, 32'd0);
        step();
        chk("n3_validD", {31'b0, s_valid}, 32'd1);
        chk("n3_pcD", s_pc, 32'h200);
        step();
        chk("n4_pcD", s_pc, 32'h204);
        repeat (4) step();

        // Back-to-back redirects, last wins, PC wraps
        lat = 3;
        wait_outst(2, 20);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        wait_valid("wrap_f8", 32'hFFFF_FFF8, 20);
        wait_valid("wrap_fc", 32'hFFFF_FFFC, 20);
        wait_valid("wrap_0", 32'h0, 20);
        repeat (6) step();

        // Reset mid-stream; memory answers stale requests afterwards
        wait_outst(2, 20);
        reset = 1'b1;
        step();
        chk("midrst_req", {31'b0, s_req}, 32'd0);
        reset = 1'b0;
        gnt_en = 1'b0;
        step();
        chk("midrst_validD", {31'b0, s_valid}, 32'd0);
        chk("midrst_pcD", s_pc, 32'd0);
        chk("midrst_instrD", s_instr, 32'd0);
`ifdef FETCH_PERF_EN
        chk("midrst_perf_fetched", perf_fetched, 32'd0);
        chk("midrst_perf_dropped", perf_dropped, 32'd0);
`endif
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            step();
            chk("stale_ignored", {31'b0, s_valid}, 32'd0);
        end
        chk("stale_drained", 32'(mq.size()), 32'd0);
        gnt_en = 1'b1;
        wait_valid("post_reset", RST_PC, 20);
        repeat (10) step();

        gnt_en = 1'b0;
        repeat (20) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
